// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the mem_resp memory responder.
package mem_resp_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StCool
  } state_e;

endpackage

// File: rtl/mem_resp_if.sv
// Request/response bus between the arbiter master port and mem_resp.
interface mem_resp_if;
  import mem_resp_pkg::*;

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdy;
  logic              err;

  modport master (
    output req, wr, addr, wdata,
    input  rdata, rdy, err
  );

  modport slave (
    input  req, wr, addr, wdata,
    output rdata, rdy, err
  );

endinterface

// File: rtl/mem_resp_ram.sv
// Single-port synchronous RAM; the read register clears on clr_i, the array never does.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0] mem_q [Words];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_resp.sv
// Wait-state memory responder: IDLE -> WAIT -> RESP -> COOL, one access per WAIT_CYCLES+3.
// Optional feature macro: MEM_RESP_RANGE_CHECK_EN (flags out-of-range addresses with err).
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic       clk,
  input logic       reset,
  mem_resp_if.slave bus
);

  localparam logic [CNT_W-1:0] WaitInit = CNT_W'(WAIT_CYCLES);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wr_q;
  logic                  oor_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  rdy_q;
  logic                  err_q;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  req_oor;
  logic                  unused_addr_bits;

  assign req_idx          = bus.addr[DEPTH_LOG2+2:3];
  assign unused_addr_bits = ^bus.addr;

`ifdef MEM_RESP_RANGE_CHECK_EN
  assign req_oor = (bus.addr >> (DEPTH_LOG2 + 3)) != '0;
`else
  assign req_oor = 1'b0;
`endif

  logic                  accept;
  logic                  go_resp;
  logic                  acc_wr;
  logic                  acc_oor;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [DATA_W-1:0]     acc_wdata;

  // With zero wait states the access happens on the accepting edge, so use the live bus.
  always_comb begin
    accept = (state_q == StIdle) && bus.req;
    if (state_q == StIdle) begin
      acc_wr    = bus.wr;
      acc_oor   = req_oor;
      acc_idx   = req_idx;
      acc_wdata = bus.wdata;
    end else begin
      acc_wr    = wr_q;
      acc_oor   = oor_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
    end
    go_resp = (accept && (WAIT_CYCLES == 0)) ||
              ((state_q == StWait) && (cnt_q == CNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdy_q <= go_resp;
      err_q <= go_resp && acc_oor;
      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            wr_q    <= bus.wr;
            oor_q   <= req_oor;
            idx_q   <= req_idx;
            wdata_q <= bus.wdata;
            cnt_q   <= WaitInit;
            state_q <= (WAIT_CYCLES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          if (cnt_q == CNT_W'(1)) begin
            state_q <= StResp;
          end
        end
        StResp:  state_q <= StCool;
        StCool:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  mem_resp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk),
    .clr_i   (reset || (go_resp && (acc_wr || acc_oor))),
    .en_i    (go_resp && !reset && !acc_oor),
    .we_i    (acc_wr),
    .idx_i   (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (bus.rdata)
  );

  assign bus.rdy = rdy_q;
  assign bus.err = err_q;

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10: log2 of the number of 64-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: wait states between accepting a request and responding, range 0..15.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req, input, 1: request valid from the arbiter master port.
REQ-006 SHALL have port wr, input, 1: 1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port addr, input, 64: byte address; bits [2:0] are ignored.
REQ-008 SHALL have port wdata, input, 64: write data from the master (the arbiter dout_m).
REQ-009 SHALL have port rdata, output, 64: read data to the master (the arbiter din_m); registered.
REQ-010 SHALL have port rdy, output, 1: one-cycle completion pulse; registered.
REQ-011 SHALL have port err, output, 1: address-range error, valid with rdy (see Configuration).

Function
REQ-012 SHALL implement states IDLE, WAIT, RESP and COOL.
REQ-013 In IDLE, req=1 at a rising edge SHALL latch wr, addr[DEPTH_LOG2+2:3] and wdata, load the counter with WAIT_CYCLES, and go to WAIT, or go to RESP when WAIT_CYCLES=0.
REQ-014 In WAIT, the counter SHALL decrement each cycle, and the block SHALL go to RESP at the edge where the counter equals 1.
REQ-015 On the edge entering RESP, a write SHALL commit the latched wdata to the latched index, and a read SHALL load rdata from that index.
REQ-016 rdy SHALL be 1 only while in RESP: exactly one cycle per accepted request; rdata SHALL be 0 for writes.
REQ-017 If req=1 is sampled in IDLE at edge N, rdy SHALL be high in the cycle after edge N+WAIT_CYCLES.
REQ-018 RESP SHALL always go to COOL, and COOL SHALL always go to IDLE.
REQ-019 req SHALL be ignored in RESP and COOL: the master's req is still high for one cycle after rdy, and the arbiter re-selects in that cycle.
REQ-020 Changes in addr, wr or wdata after acceptance SHALL have no effect on the pending access.
REQ-021 rdata SHALL hold its last value outside RESP.
REQ-022 Sustained throughput SHALL be one access per WAIT_CYCLES+3 cycles.
REQ-023 The counter SHALL be 4 bits, unsigned, and SHALL never wrap below 0.

Reset
REQ-024 reset=1 SHALL force state=IDLE, rdy=0, rdata=0, err=0 and counter=0.
REQ-025 Reset mid-operation SHALL abort the pending access with no memory write and no rdy; earlier committed writes SHALL be retained.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 The macro MEM_RESP_RANGE_CHECK_EN SHALL control range checking.
- Defined: a request with any of addr[63:DEPTH_LOG2+3] nonzero SHALL perform no memory access and SHALL return rdata=0 and err=1 in the RESP cycle, with the same timing as a normal access.
- Undefined: the upper address bits SHALL be ignored (aliasing), and err SHALL be tied to 0.

Structure
REQ-028 Package mem_resp_pkg SHALL hold the state enum, DATA_W=64, ADDR_W=64 and the counter width.
REQ-029 Sub-module mem_resp_ram SHALL provide the single-port synchronous RAM, 2^DEPTH_LOG2 x 64, with one write-or-read port per edge.
REQ-030 The FSM, counter and latches SHALL reside in mem_resp.

Verification (WAIT_CYCLES=2 unless stated otherwise)
REQ-031 Write then read: write addr 0x40, data 0xDEADBEEF_CAFEF00D, then read 0x40 -> rdy 3 cycles after each acceptance; rdata=0xDEADBEEF_CAFEF00D.
REQ-032 Back-to-back: req held high across two reads -> second acceptance exactly 5 cycles after the first; no double rdy for the first request.
REQ-033 WAIT_CYCLES=0: read at edge N -> rdy in the cycle after edge N; COOL still observed.
REQ-034 Reset mid-operation: reset asserted in WAIT during a write of 0x1234 to 0x80 -> no rdy; a later read of 0x80 returns the prior value.
REQ-035 Range check, with MEM_RESP_RANGE_CHECK_EN defined and DEPTH_LOG2=10: read addr 0x2000 -> rdy=1, err=1, rdata=0; without the macro -> aliases to word 0, err=0.
REQ-036 Input changes: addr changed from 0x08 to 0x10 during WAIT -> access uses 0x08.
